// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage that runs a req/ready data-memory handshake and stalls upstream while an access is in flight
module mem_access_stage #(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        mem_to_reg_in,
  input  logic        reg_write_en_in,
  input  logic [4:0]  rd_reg_addr_in,
  input  logic [31:0] ALU_result_in,
  input  logic [31:0] read_data_2_in,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic        stall_out,
  output logic [31:0] read_data_out,
  output logic [31:0] ALU_result_out,
  output logic [4:0]  rd_reg_addr_out,
  output logic        reg_write_en_out,
  output logic        mem_to_reg_out,
  output logic        mem_error_out
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state;
  logic [CW-1:0] wait_cnt;
  logic lat_m2r, lat_rw;
  logic [4:0] lat_rd;
  logic [31:0] lat_alu;
  logic acc;
  assign acc = mem_read_in | mem_write_in;
  assign stall_out = !reset & ((state == IDLE & acc) | state == ACCESS);
  // WB outputs default to a bubble every edge; only pass-through and a completed access override it
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      wait_cnt <= '0;
      lat_m2r <= 1'b0;
      lat_rw <= 1'b0;
      lat_rd <= '0;
      lat_alu <= '0;
      dmem_req <= 1'b0;
      dmem_we <= 1'b0;
      dmem_addr <= '0;
      dmem_wdata <= '0;
      read_data_out <= '0;
      ALU_result_out <= '0;
      rd_reg_addr_out <= '0;
      reg_write_en_out <= 1'b0;
      mem_to_reg_out <= 1'b0;
      mem_error_out <= 1'b0;
    end else begin
      read_data_out <= '0;
      ALU_result_out <= '0;
      rd_reg_addr_out <= '0;
      reg_write_en_out <= 1'b0;
      mem_to_reg_out <= 1'b0;
      mem_error_out <= 1'b0;
      case (state)
        IDLE:
          if (!acc) begin
            ALU_result_out <= ALU_result_in;
            rd_reg_addr_out <= rd_reg_addr_in;
            reg_write_en_out <= reg_write_en_in;
            mem_to_reg_out <= mem_to_reg_in;
          end else if (ALU_result_in[1:0] == 2'b00) begin
            lat_m2r <= mem_to_reg_in;
            lat_rw <= reg_write_en_in;
            lat_rd <= rd_reg_addr_in;
            lat_alu <= ALU_result_in;
            dmem_req <= 1'b1;
            dmem_we <= mem_write_in;
            dmem_addr <= {ALU_result_in[31:2], 2'b00};
            dmem_wdata <= mem_write_in ? read_data_2_in : '0;
            wait_cnt <= '0;
            state <= ACCESS;
          end else begin
            mem_error_out <= 1'b1;
            state <= DONE;
          end
        ACCESS:
          if (dmem_ready || wait_cnt == CW'(MAX_WAIT - 1)) begin
            dmem_req <= 1'b0;
            dmem_we <= 1'b0;
            dmem_addr <= '0;
            dmem_wdata <= '0;
            mem_error_out <= !dmem_ready;
            state <= DONE;
            if (dmem_ready) begin
              ALU_result_out <= lat_alu;
              rd_reg_addr_out <= lat_rd;
              reg_write_en_out <= lat_rw;
              mem_to_reg_out <= lat_m2r;
              read_data_out <= dmem_we ? '0 : dmem_rdata;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: randomized instruction stream checked against a per-instruction timeline model
module tb_mem_access_stage;
  localparam int MW = 4;
  logic clk = 1'b0, reset;
  logic mem_read_in, mem_write_in, mem_to_reg_in, reg_write_en_in, dmem_ready;
  logic [4:0] rd_reg_addr_in, rd_reg_addr_out;
  logic [31:0] ALU_result_in, read_data_2_in, dmem_rdata, dmem_addr, dmem_wdata;
  logic [31:0] read_data_out, ALU_result_out;
  logic dmem_req, dmem_we, stall_out, reg_write_en_out, mem_to_reg_out, mem_error_out;
  typedef struct packed {
    logic rw;
    logic m2r;
    logic [4:0] rd;
    logic [31:0] alu;
    logic [31:0] data;
  } wb_t;
  wb_t exp_wb;
  logic exp_err;
  int n_tests = 0, n_fail = 0;

  mem_access_stage #(.MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .mem_to_reg_in(mem_to_reg_in), .reg_write_en_in(reg_write_en_in),
    .rd_reg_addr_in(rd_reg_addr_in), .ALU_result_in(ALU_result_in),
    .read_data_2_in(read_data_2_in), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .stall_out(stall_out), .read_data_out(read_data_out), .ALU_result_out(ALU_result_out),
    .rd_reg_addr_out(rd_reg_addr_out), .reg_write_en_out(reg_write_en_out),
    .mem_to_reg_out(mem_to_reg_out), .mem_error_out(mem_error_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // checks one cycle's outputs at the falling edge, then advances to just after the next rising edge
  task automatic look(input string tag, input logic stall, input logic req, input logic we,
                      input logic [31:0] addr, input logic [31:0] wdata, input wb_t wb, input logic err);
    wb_t got;
    @(negedge clk);
    got = '{reg_write_en_out, mem_to_reg_out, rd_reg_addr_out, ALU_result_out, read_data_out};
    chk({tag, " stall"}, 72'(stall_out), 72'(stall));
    chk({tag, " dmem"}, {dmem_req, dmem_we, dmem_addr, dmem_wdata}, {req, we, addr, wdata});
    chk({tag, " wb"}, 72'(got), 72'(wb));
    chk({tag, " err"}, 72'(mem_error_out), 72'(err));
    @(posedge clk);
    #1;
  endtask

  // w = non-ready ACCESS cycles before ready; w >= MW means memory never answers
  task automatic run(input logic rd_, input logic wr, input logic m2r, input logic rw,
                     input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] data, input int w);
    wb_t lat;
    bit last;
    lat = '{rw, m2r, rd, alu, 32'h0};
    mem_read_in = rd_; mem_write_in = wr; mem_to_reg_in = m2r; reg_write_en_in = rw;
    rd_reg_addr_in = rd; ALU_result_in = alu; read_data_2_in = data; dmem_ready = 1'b0;
    if (!(rd_ | wr)) begin
      look("pass", 1'b0, 1'b0, 1'b0, 0, 0, exp_wb, exp_err);
      exp_wb = lat; exp_err = 1'b0;
      return;
    end
    if (alu[1:0] != 2'b00) begin
      look("mis_idle", 1'b1, 1'b0, 1'b0, 0, 0, exp_wb, exp_err);
      look("mis_done", 1'b0, 1'b0, 1'b0, 0, 0, '0, 1'b1);
      exp_wb = '0; exp_err = 1'b0;
      return;
    end
    look("mem_idle", 1'b1, 1'b0, 1'b0, 0, 0, exp_wb, exp_err);
    for (int i = 0; i < MW; i++) begin
      last = (i == w);
      dmem_ready = last;
      dmem_rdata = $urandom;
      if (last && !wr) lat.data = dmem_rdata;
      look("access", 1'b1, 1'b1, wr, alu, wr ? data : 32'h0, '0, 1'b0);
      if (last) break;
    end
    dmem_ready = 1'b0;
    dmem_rdata = $urandom;
    look("done", 1'b0, 1'b0, 1'b0, 0, 0, (w >= MW) ? wb_t'('0) : lat, w >= MW);
    exp_wb = '0; exp_err = 1'b0;
  endtask

  initial begin
    logic [3:0] r;
    logic [31:0] a;
    reset = 1'b1; dmem_ready = 1'b0; dmem_rdata = '0;
    mem_read_in = 1'b1; mem_write_in = 1'b0; mem_to_reg_in = 1'b1; reg_write_en_in = 1'b1;
    rd_reg_addr_in = 5'd9; ALU_result_in = 32'h200; read_data_2_in = 32'h77;
    @(posedge clk);
    #1;
    look("reset0", 1'b0, 1'b0, 1'b0, 0, 0, '0, 1'b0);
    look("reset1", 1'b0, 1'b0, 1'b0, 0, 0, '0, 1'b0);
    reset = 1'b0;
    exp_wb = '0; exp_err = 1'b0;
    run(1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h1234, 32'h0, 0);
    run(1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 32'h100, 32'h0, 2);
    run(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h40, 32'hA5A5A5A5, 0);
    run(1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 32'h80, 32'h0, MW);
    run(1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 32'h102, 32'h0, 0);
    run(1'b1, 1'b0, 1'b1, 1'b1, 5'd6, 32'h104, 32'h0, MW - 1);
    run(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 0);
    // reset arrives while a load is waiting on memory
    mem_read_in = 1'b1; mem_write_in = 1'b0; mem_to_reg_in = 1'b1; reg_write_en_in = 1'b1;
    rd_reg_addr_in = 5'd8; ALU_result_in = 32'h300; dmem_ready = 1'b0;
    look("rst_idle", 1'b1, 1'b0, 1'b0, 0, 0, exp_wb, exp_err);
    look("rst_acc", 1'b1, 1'b1, 1'b0, 32'h300, 0, '0, 1'b0);
    reset = 1'b1;
    look("rst_hi", 1'b0, 1'b1, 1'b0, 32'h300, 0, '0, 1'b0);
    reset = 1'b0;
    mem_read_in = 1'b0; mem_to_reg_in = 1'b0; reg_write_en_in = 1'b0;
    rd_reg_addr_in = '0; ALU_result_in = '0;
    look("rst_after", 1'b0, 1'b0, 1'b0, 0, 0, '0, 1'b0);
    exp_wb = '0; exp_err = 1'b0;
    for (int k = 0; k < 300; k++) begin
      r = 4'($urandom_range(0, 15));
      a = $urandom;
      if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
      run(r[1], r[0], r[2], r[3], 5'($urandom), a, $urandom, int'($urandom_range(0, MW + 1)));
    end
    run(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
